// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back controller.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // x0 is hardwired, so it is never written and never tracked.
  function automatic logic is_writable(input logic [ADDR_W-1:0] rd);
    return (rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small synchronous FIFO holding memory-return write-backs until the
// shared register-file write port is free.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_MAX);
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Storage, pointers (wrapping modulo DEPTH) and occupancy count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller: arbitrates ALU and memory returns onto the single
// register-file write port and tracks pending writes to stall decode on hazards.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int MEM_FIFO_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_rd_en,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] dec_rs1,
  input  logic [ADDR_W-1:0] dec_rs2,
  input  logic              dec_use_rs1,
  input  logic              dec_use_rs2,
  input  logic [ADDR_W-1:0] dec_rd,
  input  logic              dec_rd_en,
  output logic              stall,
  input  logic              alu_wb_valid,
  input  logic [ADDR_W-1:0] alu_wb_rd,
  input  logic [DATA_W-1:0] alu_wb_data,
  input  logic              mem_wb_valid,
  input  logic [ADDR_W-1:0] mem_wb_rd,
  input  logic [DATA_W-1:0] mem_wb_data,
  output logic              mem_wb_ready,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_addr_rd,
  output logic [DATA_W-1:0] rf_data_rd,
  output logic              busy,
  output logic              err_unexpected_wb
);

  localparam int FIFO_W = ADDR_W + DATA_W;
  localparam int CNT_W  = $clog2(MEM_FIFO_DEPTH) + 1;
  localparam logic [NUM_REGS-1:0] REG_ONE  = NUM_REGS'(1);
  localparam logic [NUM_REGS-1:0] ZERO_MASK = ~(REG_ONE << REG_ZERO);

  logic [NUM_REGS-1:0] pending_r;
  logic [NUM_REGS-1:0] pending_next_s;
  logic [NUM_REGS-1:0] set_mask_s;
  logic [NUM_REGS-1:0] clr_mask_s;
  logic                rf_write_enable_r;
  logic [ADDR_W-1:0]   rf_addr_rd_r;
  logic [DATA_W-1:0]   rf_data_rd_r;
  logic                err_r;
  wb_req_t             win_s;
  logic                fifo_pop_s;
  logic                fifo_push_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [CNT_W-1:0]    fifo_count_s;
  logic [FIFO_W-1:0]   fifo_head_s;
  logic                wr_s;
  logic                unexpected_s;
  logic                set_s;
  logic                stall_s;

  assign mem_wb_ready = ~fifo_full_s;
  assign fifo_push_s  = mem_wb_valid & ~fifo_full_s;

  wb_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (MEM_FIFO_DEPTH)
  ) u_mem_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push_s),
    .push_data ({mem_wb_rd, mem_wb_data}),
    .pop       (fifo_pop_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Fixed-priority arbitration: the ALU cannot be back-pressured, memory waits.
  always_comb begin
    win_s      = '0;
    fifo_pop_s = 1'b0;
    if (alu_wb_valid) begin
      win_s.valid = 1'b1;
      win_s.rd    = alu_wb_rd;
      win_s.data  = alu_wb_data;
    end else if (!fifo_empty_s) begin
      win_s.valid = 1'b1;
      win_s.rd    = fifo_head_s[FIFO_W-1:DATA_W];
      win_s.data  = fifo_head_s[DATA_W-1:0];
      fifo_pop_s  = 1'b1;
    end else begin
      win_s      = '0;
      fifo_pop_s = 1'b0;
    end
  end

  assign wr_s         = win_s.valid & is_writable(win_s.rd);
  assign unexpected_s = wr_s & ~pending_r[win_s.rd];

  assign stall_s = (dec_use_rs1 & pending_r[dec_rs1]) |
                   (dec_use_rs2 & pending_r[dec_rs2]) |
                   (dec_rd_en   & pending_r[dec_rd]);
  assign set_s   = issue_valid & issue_rd_en & is_writable(issue_rd) & ~stall_s;

  // Clear lands with the register-file capture; a same-index set overrides it.
  assign set_mask_s     = set_s ? (REG_ONE << issue_rd) : {NUM_REGS{1'b0}};
  assign clr_mask_s     = rf_write_enable_r ? (REG_ONE << rf_addr_rd_r) : {NUM_REGS{1'b0}};
  assign pending_next_s = ((pending_r & ~clr_mask_s) | set_mask_s) & ZERO_MASK;

  // Scoreboard, registered write port and sticky error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_r         <= {NUM_REGS{1'b0}};
      rf_write_enable_r <= 1'b0;
      rf_addr_rd_r      <= {ADDR_W{1'b0}};
      rf_data_rd_r      <= {DATA_W{1'b0}};
      err_r             <= 1'b0;
    end else begin
      pending_r         <= pending_next_s;
      rf_write_enable_r <= wr_s;
      if (wr_s) begin
        rf_addr_rd_r <= win_s.rd;
        rf_data_rd_r <= win_s.data;
      end
      err_r <= err_r | unexpected_s;
    end
  end

  assign stall             = stall_s;
  assign rf_write_enable   = rf_write_enable_r;
  assign rf_addr_rd        = rf_addr_rd_r;
  assign rf_data_rd        = rf_data_rd_r;
  assign err_unexpected_wb = err_r;
  assign busy              = (|pending_r) | (fifo_count_s != {CNT_W{1'b0}});

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_rd_en = 1'b0;
  logic [4:0]  issue_rd = 5'd0;
  logic [4:0]  dec_rs1 = 5'd0;
  logic [4:0]  dec_rs2 = 5'd0;
  logic        dec_use_rs1 = 1'b0;
  logic        dec_use_rs2 = 1'b0;
  logic [4:0]  dec_rd = 5'd0;
  logic        dec_rd_en = 1'b0;
  logic        stall;
  logic        alu_wb_valid = 1'b0;
  logic [4:0]  alu_wb_rd = 5'd0;
  logic [31:0] alu_wb_data = 32'd0;
  logic        mem_wb_valid = 1'b0;
  logic [4:0]  mem_wb_rd = 5'd0;
  logic [31:0] mem_wb_data = 32'd0;
  logic        mem_wb_ready;
  logic        rf_write_enable;
  logic [4:0]  rf_addr_rd;
  logic [31:0] rf_data_rd;
  logic        busy;
  logic        err_unexpected_wb;

  int tests_run = 0;
  int tests_failed = 0;

  regfile_wb_arbiter #(.MEM_FIFO_DEPTH(2)) dut (
    .clock             (clock),
    .reset             (reset),
    .issue_valid       (issue_valid),
    .issue_rd_en       (issue_rd_en),
    .issue_rd          (issue_rd),
    .dec_rs1           (dec_rs1),
    .dec_rs2           (dec_rs2),
    .dec_use_rs1       (dec_use_rs1),
    .dec_use_rs2       (dec_use_rs2),
    .dec_rd            (dec_rd),
    .dec_rd_en         (dec_rd_en),
    .stall             (stall),
    .alu_wb_valid      (alu_wb_valid),
    .alu_wb_rd         (alu_wb_rd),
    .alu_wb_data       (alu_wb_data),
    .mem_wb_valid      (mem_wb_valid),
    .mem_wb_rd         (mem_wb_rd),
    .mem_wb_data       (mem_wb_data),
    .mem_wb_ready      (mem_wb_ready),
    .rf_write_enable   (rf_write_enable),
    .rf_addr_rd        (rf_addr_rd),
    .rf_data_rd        (rf_data_rd),
    .busy              (busy),
    .err_unexpected_wb (err_unexpected_wb)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_rd_en = 1'b1;
    issue_rd    = rd;
    tick();
    issue_valid = 1'b0;
    issue_rd_en = 1'b0;
  endtask

  initial begin
    // Reset asserted mid-cycle takes effect immediately.
    #2 reset = 1'b1;
    #1;
    check("rst_we",    32'(rf_write_enable), 32'd0);
    check("rst_addr",  32'(rf_addr_rd),      32'd0);
    check("rst_stall", 32'(stall),           32'd0);
    check("rst_ready", 32'(mem_wb_ready),    32'd1);
    check("rst_busy",  32'(busy),            32'd0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;

    // RAW hazard on x5 cleared by an ALU write-back.
    issue(5'd5);
    dec_rs1 = 5'd5; dec_use_rs1 = 1'b1;
    #1;
    check("raw_stall_c1", 32'(stall), 32'd1);
    check("raw_busy",     32'(busy),  32'd1);
    tick();
    tick();
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'hDEADBEEF;
    #1;
    check("raw_stall_c3", 32'(stall), 32'd1);
    tick();
    alu_wb_valid = 1'b0;
    #1;
    check("raw_we_c4",    32'(rf_write_enable), 32'd1);
    check("raw_addr_c4",  32'(rf_addr_rd),      32'd5);
    check("raw_data_c4",  rf_data_rd,           32'hDEADBEEF);
    check("raw_stall_c4", 32'(stall),           32'd1);
    tick();
    check("raw_stall_c5", 32'(stall),           32'd0);
    check("raw_we_c5",    32'(rf_write_enable), 32'd0);
    check("raw_err",      32'(err_unexpected_wb), 32'd0);
    dec_use_rs1 = 1'b0; dec_rs1 = 5'd0;

    // Same-cycle ALU and memory returns; WAW check on decode.
    issue(5'd3);
    issue(5'd7);
    dec_rd = 5'd3; dec_rd_en = 1'b1;
    #1;
    check("waw_stall", 32'(stall), 32'd1);
    dec_rd_en = 1'b0; dec_rd = 5'd0;
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd3; alu_wb_data = 32'h11;
    mem_wb_valid = 1'b1; mem_wb_rd = 5'd7; mem_wb_data = 32'h22;
    #1;
    check("cf_ready", 32'(mem_wb_ready), 32'd1);
    tick();
    alu_wb_valid = 1'b0; mem_wb_valid = 1'b0;
    #1;
    check("cf_we1",   32'(rf_write_enable), 32'd1);
    check("cf_addr1", 32'(rf_addr_rd),      32'd3);
    check("cf_data1", rf_data_rd,           32'h11);
    tick();
    check("cf_we2",   32'(rf_write_enable), 32'd1);
    check("cf_addr2", 32'(rf_addr_rd),      32'd7);
    check("cf_data2", rf_data_rd,           32'h22);
    tick();
    check("cf_idle_we",  32'(rf_write_enable), 32'd0);
    check("cf_idle_bsy", 32'(busy),            32'd0);

    // Back-pressure: four ALU cycles starve the memory FIFO.
    issue(5'd1); issue(5'd2); issue(5'd3); issue(5'd4);
    issue(5'd8); issue(5'd9); issue(5'd10);
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd1; alu_wb_data = 32'hA1;
    mem_wb_valid = 1'b1; mem_wb_rd = 5'd8; mem_wb_data = 32'h80;
    #1;
    check("bp_ready0", 32'(mem_wb_ready), 32'd1);
    tick();
    alu_wb_rd = 5'd2; alu_wb_data = 32'hA2;
    mem_wb_rd = 5'd9; mem_wb_data = 32'h90;
    #1;
    check("bp_ready1", 32'(mem_wb_ready), 32'd1);
    check("bp_addr1",  32'(rf_addr_rd),   32'd1);
    check("bp_data1",  rf_data_rd,        32'hA1);
    tick();
    alu_wb_rd = 5'd3; alu_wb_data = 32'hA3;
    mem_wb_rd = 5'd10; mem_wb_data = 32'h100;
    #1;
    check("bp_ready2", 32'(mem_wb_ready), 32'd0);
    tick();
    alu_wb_rd = 5'd4; alu_wb_data = 32'hA4;
    #1;
    check("bp_ready3", 32'(mem_wb_ready), 32'd0);
    tick();
    alu_wb_valid = 1'b0;
    #1;
    check("bp_ready4", 32'(mem_wb_ready), 32'd0);
    check("bp_addr4",  32'(rf_addr_rd),   32'd4);
    tick();
    check("bp_ready5", 32'(mem_wb_ready), 32'd1);
    check("bp_addr8",  32'(rf_addr_rd),   32'd8);
    check("bp_data8",  rf_data_rd,        32'h80);
    tick();
    mem_wb_valid = 1'b0;
    #1;
    check("bp_addr9",  32'(rf_addr_rd),   32'd9);
    check("bp_data9",  rf_data_rd,        32'h90);
    tick();
    check("bp_we10",   32'(rf_write_enable), 32'd1);
    check("bp_addr10", 32'(rf_addr_rd),      32'd10);
    check("bp_data10", rf_data_rd,           32'h100);
    tick();
    check("bp_idle_we",  32'(rf_write_enable), 32'd0);
    check("bp_idle_bsy", 32'(busy),            32'd0);
    check("bp_err",      32'(err_unexpected_wb), 32'd0);

    // x0 write-back is dropped silently; write to non-pending x9 flags an error.
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd0; alu_wb_data = 32'h55;
    tick();
    alu_wb_valid = 1'b0;
    #1;
    check("z_we",  32'(rf_write_enable),   32'd0);
    check("z_err", 32'(err_unexpected_wb), 32'd0);
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd9; alu_wb_data = 32'h99;
    tick();
    alu_wb_valid = 1'b0;
    #1;
    check("u_we",   32'(rf_write_enable),   32'd1);
    check("u_addr", 32'(rf_addr_rd),        32'd9);
    check("u_data", rf_data_rd,             32'h99);
    check("u_err",  32'(err_unexpected_wb), 32'd1);
    tick();
    tick();
    check("u_err_sticky", 32'(err_unexpected_wb), 32'd1);

    // Reset while the FIFO is full and x4 is pending.
    issue(5'd4);
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd0; alu_wb_data = 32'h0;
    mem_wb_valid = 1'b1; mem_wb_rd = 5'd11; mem_wb_data = 32'hB;
    tick();
    mem_wb_rd = 5'd12; mem_wb_data = 32'hC;
    tick();
    mem_wb_valid = 1'b0;
    #1;
    check("pr_busy",  32'(busy),              32'd1);
    check("pr_ready", 32'(mem_wb_ready),      32'd0);
    #2 reset = 1'b1;
    alu_wb_valid = 1'b0;
    dec_rd = 5'd4; dec_rd_en = 1'b1;
    #1;
    check("r2_busy",  32'(busy),              32'd0);
    check("r2_ready", 32'(mem_wb_ready),      32'd1);
    check("r2_err",   32'(err_unexpected_wb), 32'd0);
    check("r2_stall", 32'(stall),             32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r2_no_we",   32'(rf_write_enable), 32'd0);
      check("r2_no_busy", 32'(busy),            32'd0);
    end
    dec_rd_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
